// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: owns the PWM configuration registers and runs an
// autonomous fade engine that walks the duty cycle between two bounds.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   wr_valid          single-cycle write strobe from the SPI register decoder
//   wr_addr, wr_data  register address / write data
//   tick              one-cycle prescaler strobe, fade timebase
//   en_reg_out_*      output enables, channels 7..0 / 15..8
//   en_reg_pwm_*      PWM mode enables, channels 7..0 / 15..8
//   pwm_duty_cycle    current duty cycle (SPI-written or fade-driven)
//   fade_busy         high while the fade engine is in RUN or STEP
//
// Register map:
//   0x00 out 7..0, 0x01 out 15..8, 0x02 pwm 7..0, 0x03 pwm 15..8, 0x04 duty
//   0x05 FADE_CTRL (bit0 enable, bit1 mode: 0 triangle, 1 sawtooth)
//   0x06 FADE_STEP, 0x07 FADE_HOLD, 0x08 FADE_MIN, 0x09 FADE_MAX

module pwm_fade_controller #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned TICK_HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              tick,
   output logic [7:0]        en_reg_out_7_0,
   output logic [7:0]        en_reg_out_15_8,
   output logic [7:0]        en_reg_pwm_7_0,
   output logic [7:0]        en_reg_pwm_15_8,
   output logic [7:0]        pwm_duty_cycle,
   output logic              fade_busy
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned SUM_W  = DATA_W + 1;

   localparam logic [ADDR_W-1:0] A_OUT_LO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_OUT_HI = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PWM_LO = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_PWM_HI = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_DUTY   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(6);
   localparam logic [ADDR_W-1:0] A_HOLD   = ADDR_W'(7);
   localparam logic [ADDR_W-1:0] A_MIN    = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] A_MAX    = ADDR_W'(9);

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   // Register state
   state_e                 state_q,    state_d;
   logic [DATA_W-1:0]      out_lo_q,   out_lo_d;
   logic [DATA_W-1:0]      out_hi_q,   out_hi_d;
   logic [DATA_W-1:0]      pwm_lo_q,   pwm_lo_d;
   logic [DATA_W-1:0]      pwm_hi_q,   pwm_hi_d;
   logic [DATA_W-1:0]      duty_q,     duty_d;
   logic                   en_q,       en_d;
   logic                   mode_q,     mode_d;
   logic [DATA_W-1:0]      step_q,     step_d;
   logic [DATA_W-1:0]      hold_q,     hold_d;
   logic [DATA_W-1:0]      min_q,      min_d;
   logic [DATA_W-1:0]      max_q,      max_d;
   logic                   dir_q,      dir_d;
   logic [TICK_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic                   busy_q,     busy_d;

   // Step arithmetic results
   logic [SUM_W-1:0]  up_sum_c;
   logic [SUM_W-1:0]  down_floor_c;
   logic [DATA_W-1:0] next_duty_c;
   logic              next_dir_c;
   logic              duty_wr_c;
   logic              go_c;

   // Next duty/direction for one fade step; 9-bit sums avoid 8-bit wrap.
   // Out-of-range duty snaps to the nearest bound before normal stepping.
   always_comb begin
      up_sum_c     = {1'b0, duty_q} + {1'b0, step_q};
      down_floor_c = {1'b0, min_q} + {1'b0, step_q};
      next_duty_c  = duty_q;
      next_dir_c   = dir_q;
      if (duty_q < min_q) begin
         next_duty_c = min_q;
         if (!mode_q) next_dir_c = DIR_UP;
      end else if (duty_q > max_q) begin
         next_duty_c = max_q;
         if (!mode_q) next_dir_c = DIR_DOWN;
      end else if (mode_q) begin
         if (up_sum_c > {1'b0, max_q}) next_duty_c = min_q;
         else                          next_duty_c = up_sum_c[DATA_W-1:0];
      end else if (dir_q == DIR_UP) begin
         if (up_sum_c >= {1'b0, max_q}) begin
            next_duty_c = max_q;
            next_dir_c  = DIR_DOWN;
         end else begin
            next_duty_c = up_sum_c[DATA_W-1:0];
         end
      end else begin
         if ({1'b0, duty_q} <= down_floor_c) begin
            next_duty_c = min_q;
            next_dir_c  = DIR_UP;
         end else begin
            next_duty_c = duty_q - step_q;
         end
      end
   end

   // Register writes plus fade sequencing; enable/bounds are judged on the
   // post-write values so a disabling write lands in IDLE on the next cycle.
   always_comb begin
      state_d    = state_q;
      out_lo_d   = out_lo_q;
      out_hi_d   = out_hi_q;
      pwm_lo_d   = pwm_lo_q;
      pwm_hi_d   = pwm_hi_q;
      duty_d     = duty_q;
      en_d       = en_q;
      mode_d     = mode_q;
      step_d     = step_q;
      hold_d     = hold_q;
      min_d      = min_q;
      max_d      = max_q;
      dir_d      = dir_q;
      hold_cnt_d = hold_cnt_q;
      duty_wr_c  = 1'b0;

      if (wr_valid) begin
         unique case (wr_addr)
            A_OUT_LO: out_lo_d = wr_data;
            A_OUT_HI: out_hi_d = wr_data;
            A_PWM_LO: pwm_lo_d = wr_data;
            A_PWM_HI: pwm_hi_d = wr_data;
            A_DUTY: begin
               duty_d    = wr_data;
               duty_wr_c = 1'b1;
            end
            A_CTRL: begin
               en_d   = wr_data[0];
               mode_d = wr_data[1];
            end
            A_STEP:  step_d = wr_data;
            A_HOLD:  hold_d = wr_data;
            A_MIN:   min_d  = wr_data;
            A_MAX:   max_d  = wr_data;
            default: ;
         endcase
      end

      go_c = en_d && (min_d <= max_d);

      unique case (state_q)
         ST_IDLE: begin
            if (go_c) begin
               state_d    = ST_RUN;
               dir_d      = DIR_UP;
               hold_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (!go_c) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (hold_cnt_q == TICK_HOLD_W'(hold_q)) begin
                  state_d    = ST_STEP;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + TICK_HOLD_W'(1);
               end
            end
         end
         ST_STEP: begin
            // A same-cycle SPI duty write wins and the step is dropped.
            hold_cnt_d = '0;
            if (!go_c) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
               if (!duty_wr_c) begin
                  duty_d = next_duty_c;
                  dir_d  = next_dir_c;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         out_lo_q   <= '0;
         out_hi_q   <= '0;
         pwm_lo_q   <= '0;
         pwm_hi_q   <= '0;
         duty_q     <= '0;
         en_q       <= 1'b0;
         mode_q     <= 1'b0;
         step_q     <= DATA_W'(1);
         hold_q     <= '0;
         min_q      <= '0;
         max_q      <= '1;
         dir_q      <= DIR_UP;
         hold_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_lo_q   <= out_lo_d;
         out_hi_q   <= out_hi_d;
         pwm_lo_q   <= pwm_lo_d;
         pwm_hi_q   <= pwm_hi_d;
         duty_q     <= duty_d;
         en_q       <= en_d;
         mode_q     <= mode_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         min_q      <= min_d;
         max_q      <= max_d;
         dir_q      <= dir_d;
         hold_cnt_q <= hold_cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign en_reg_out_7_0  = out_lo_q;
   assign en_reg_out_15_8 = out_hi_q;
   assign en_reg_pwm_7_0  = pwm_lo_q;
   assign en_reg_pwm_15_8 = pwm_hi_q;
   assign pwm_duty_cycle  = duty_q;
   assign fade_busy       = busy_q;

endmodule

// File: doc/pwm_fade_controller.md
Name: pwm_fade_controller

Overview:
Register owner and sequencer for the 16-channel PWM peripheral. Holds the five PWM configuration registers and accepts single-cycle writes from the SPI register decoder. Contains an autonomous fade engine that steps pwm_duty_cycle between programmable bounds on a prescaled tick. Sits between the SPI peripheral's write port and the PWM peripheral's configuration inputs.

Parameters:
ADDR_W, 7, register address width
TICK_HOLD_W, 8, width of the hold-interval counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
wr_valid  input  1  single-cycle write strobe from SPI decoder
wr_addr  input  ADDR_W  register address
wr_data  input  8  write data
tick  input  1  one-cycle prescaler strobe; fade timebase
en_reg_out_7_0  output  8  output enable, channels 7..0
en_reg_out_15_8  output  8  output enable, channels 15..8
en_reg_pwm_7_0  output  8  PWM mode enable, channels 7..0
en_reg_pwm_15_8  output  8  PWM mode enable, channels 15..8
pwm_duty_cycle  output  8  current duty cycle
fade_busy  output  1  high while fade engine is in RUN or STEP

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst); all state is cleared on assertion, with no clock required.
- Register map:
  - 0x00 en_reg_out_7_0; 0x01 en_reg_out_15_8; 0x02 en_reg_pwm_7_0; 0x03 en_reg_pwm_15_8; 0x04 pwm_duty_cycle
  - 0x05 FADE_CTRL: bit0 enable, bit1 mode (0 triangle, 1 sawtooth); other bits read as 0
  - 0x06 FADE_STEP; 0x07 FADE_HOLD; 0x08 FADE_MIN; 0x09 FADE_MAX
  - Other addresses are ignored with no side effect.
- Reset values: all outputs 0, fade_busy 0, FADE_CTRL 0x00, FADE_STEP 0x01, FADE_HOLD 0x00, FADE_MIN 0x00, FADE_MAX 0xFF, dir=up, hold_cnt=0, state IDLE.
- Writes take effect on the clock edge where wr_valid=1. The output is visible the next cycle. There is no backpressure.
- FSM states:
  - IDLE: entered when enable=0, or when FADE_MIN > FADE_MAX (invalid bounds). Duty is held.
  - RUN: entered from IDLE when enable=1 and bounds are valid. On entry, dir=up and hold_cnt=0. Duty is unchanged.
    - On each tick: if hold_cnt == FADE_HOLD, go to STEP and clear hold_cnt; otherwise increment hold_cnt.
    - FADE_HOLD=0 means a step on every tick.
  - STEP: lasts one cycle, writes the next duty, then returns to RUN. If enable=0 at that point, it goes to IDLE instead.
- Step arithmetic uses a 9-bit sum/difference with no 8-bit wrap:
  - Triangle, up: if duty+step >= MAX, then duty=MAX and dir=down; else duty=duty+step.
  - Triangle, down: if duty <= MIN+step, then duty=MIN and dir=up; else duty=duty-step.
  - Sawtooth: if duty+step > MAX, then duty=MIN; else duty=duty+step. dir is ignored.
  - Duty outside [MIN,MAX] at step time: the next step clamps to the nearest bound.
  - FADE_STEP=0: the FSM still cycles and duty is unchanged.
- Simultaneous events:
  - SPI write to 0x04 in the same cycle as STEP: the SPI value wins. That step is dropped and hold_cnt restarts from 0.
  - SPI write clearing enable during RUN or STEP: IDLE the next cycle; the duty value stands.
  - Writes to FADE_MIN or FADE_MAX during RUN take effect from the next step. If this makes the bounds invalid, go to IDLE the next cycle.
  - tick during STEP is ignored.
- fade_busy = (state != IDLE), registered.
- rst asserted mid-fade returns everything to the reset values immediately.

Test Plan:
- Reset: pulse rst mid-operation → all five outputs 0x00 and fade_busy=0, asynchronously; write 0x05=0x01 afterwards → RUN starts from duty 0x00.
- Basic writes: write 0x00=0xAA, 0x03=0x55, 0x04=0x80, and address 0x0A=0xFF → en_reg_out_7_0=0xAA, en_reg_pwm_15_8=0x55, duty=0x80, nothing else changes.
- Triangle: MIN=0x10, MAX=0x40, STEP=0x18, HOLD=0, duty=0x10, CTRL=0x01, then ticks → duty sequence 0x28, 0x40, 0x28, 0x10, 0x28.
- Sawtooth with hold: MIN=0x00, MAX=0xF0, STEP=0x50, HOLD=2, CTRL=0x03, duty=0 → duty changes every 3rd tick: 0x50, 0xA0, 0xF0, 0x00.
- Collision: SPI write 0x04=0x33 in the STEP cycle → duty=0x33; the next change occurs only after HOLD+1 further ticks.
- Invalid bounds and disable: MIN=0x80, MAX=0x20 with enable=1 → fade_busy=0 and duty frozen; then CTRL=0x00 during RUN → IDLE next cycle, duty retained.
